fetch_controller: RTL

- Sequences instruction fetch for the multicycle core: owns the PC, drives the address of the synchronous 24-bit instruction memory, captures the returned word into the IR and hands it to the main control FSM through a request/valid handshake.
- Handles PC redirects from branch and jump, flags out-of-range fetches as faults, and counts retired fetches.
- Sits between the control unit and the instruction memory.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_controller_pc_reg.sv | 25 ++
 rtl/fetch_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the multicycle core's fetch path.
package core_pkg;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 24;
  localparam int MEM_DEPTH = 1024;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller_pc_reg.sv
// Program counter register: a redirect load wins over the post-capture increment.
module pc_reg #(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // The increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, captures memory data into the IR
// and flags fetches that fall outside the populated instruction memory.
module fetch_controller #(
  parameter int                ADDR_W    = core_pkg::ADDR_W,
  parameter int                DATA_W    = core_pkg::DATA_W,
  parameter int                MEM_DEPTH = core_pkg::MEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                CNT_W     = core_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_cur,
  output logic              busy,
  output logic              fetch_fault,
  output logic [CNT_W-1:0]  fetch_count
);

  import core_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_t state, state_nxt;

  logic in_range;
  logic pc_ld;
  logic pc_inc;
  logic capture;
  logic clr_valid;

  assign in_range  = ({1'b0, pc} < DEPTH_EXT);
  assign imem_addr = pc;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_ld),
    .load_val (pc_next),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect always returns to IDLE; fetch_req is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pc_load) begin
          state_nxt = IDLE;
        end else if (fetch_req) begin
          state_nxt = in_range ? WAIT : FAULT;
        end
      end
      WAIT: begin
        state_nxt = IDLE;
      end
      FAULT: begin
        if (pc_load) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    fetch_fault = 1'b0;
    pc_ld       = 1'b0;
    pc_inc      = 1'b0;
    capture     = 1'b0;
    clr_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        pc_ld     = pc_load;
        clr_valid = pc_load | fetch_req;
      end
      WAIT: begin
        busy    = 1'b1;
        pc_ld   = pc_load;
        pc_inc  = ~pc_load;
        capture = ~pc_load;
      end
      FAULT: begin
        fetch_fault = 1'b1;
        pc_ld       = pc_load;
      end
      default: begin
        clr_valid = 1'b1;
      end
    endcase
  end

  // pc_cur samples the pre-increment PC, i.e. the address the memory just read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir          <= '0;
      pc_cur      <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (capture) begin
      ir          <= imem_data;
      pc_cur      <= pc;
      ir_valid    <= 1'b1;
      fetch_count <= fetch_count + CNT_W'(1);
    end else if (clr_valid) begin
      ir_valid    <= 1'b0;
    end
  end

endmodule
